// File: rtl/zed_btn_conditioner.sv
// Push-button conditioner: per channel a 2-flop synchroniser, counter debounce,
// single-cycle press/release pulses and a hold-to-auto-repeat pulse train.
module zed_btn_conditioner #(
  parameter int unsigned NUM_BTN           = 2,
  parameter int unsigned DB_CYCLES         = 1000000,
  parameter int unsigned RPT_DELAY_CYCLES  = 50000000,
  parameter int unsigned RPT_PERIOD_CYCLES = 10000000
) (
  input  logic               GCLK,
  input  logic               RSTN,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RptMax = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                   RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int unsigned HoldW  = $clog2(RptMax + 1);

  localparam logic [DbW-1:0]   DbLast    = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] RptDelay  = HoldW'(RPT_DELAY_CYCLES);
  localparam logic [HoldW-1:0] RptPeriod = HoldW'(RPT_PERIOD_CYCLES);

  typedef enum logic [1:0] {StLow, StChkHi, StHigh, StChkLo} state_e;

  logic [NUM_BTN-1:0] s1_q, s2_q;

  always_ff @(posedge GCLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d, db_inc;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic             rpt_armed_q, rpt_armed_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             db_done;

    assign db_done  = (db_cnt_q == DbLast);
    assign db_inc   = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + DbW'(1);
    assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HoldW'(1);

    always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      rpt_armed_d = rpt_armed_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      repeat_d    = 1'b0;

      unique case (state_q)
        StLow: begin
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          rpt_armed_d = 1'b0;
          if (s2_q[i]) state_d = StChkHi;
        end
        StChkHi: begin
          if (!s2_q[i]) begin
            state_d  = StLow;
            db_cnt_d = '0;
          end else if (db_done) begin
            state_d     = StHigh;
            db_cnt_d    = '0;
            level_d     = 1'b1;
            press_d     = 1'b1;
            hold_cnt_d  = '0;
            rpt_armed_d = 1'b0;
          end else begin
            db_cnt_d = db_inc;
          end
        end
        StHigh: begin
          db_cnt_d = '0;
          if (!s2_q[i]) state_d = StChkLo;
        end
        StChkLo: begin
          if (s2_q[i]) begin
            state_d  = StHigh;
            db_cnt_d = '0;
          end else if (db_done) begin
            state_d     = StLow;
            db_cnt_d    = '0;
            level_d     = 1'b0;
            release_d   = 1'b1;
            hold_cnt_d  = '0;
            rpt_armed_d = 1'b0;
          end else begin
            db_cnt_d = db_inc;
          end
        end
        default: state_d = StLow;
      endcase

      // Cadence survives CHK_LO bounces; the release edge itself never repeats.
      if ((state_q == StHigh || state_q == StChkLo) && state_d != StLow) begin
        if (hold_inc == (rpt_armed_q ? RptPeriod : RptDelay)) begin
          repeat_d    = 1'b1;
          hold_cnt_d  = '0;
          rpt_armed_d = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
    end

    always_ff @(posedge GCLK or negedge RSTN) begin
      if (!RSTN) begin
        state_q     <= StLow;
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        rpt_armed_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        rpt_armed_q <= rpt_armed_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        repeat_q    <= repeat_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_zed_btn_conditioner.sv
// Bench for zed_btn_conditioner: per-cycle scoreboard against a run-length model,
// table of stimulus segments with hand-derived pulse counts, and reset sequences.
module tb_zed_btn_conditioner;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
  localparam int NSEG = 14;

  logic       GCLK = 1'b0;
  logic       RSTN;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 GCLK = ~GCLK;

  zed_btn_conditioner #(
    .NUM_BTN          (2),
    .DB_CYCLES        (DB),
    .RPT_DELAY_CYCLES (DLY),
    .RPT_PERIOD_CYCLES(PER)
  ) dut (
    .GCLK       (GCLK),
    .RSTN       (RSTN),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rpt;
  } obs_t;

  typedef struct {
    logic [1:0] raw;
    int         cyc;
    logic [1:0] lvl;
    int         p0, p1, r0, r1, rp0, rp1;
  } seg_t;

  obs_t       exp_q[$];
  seg_t       segs[NSEG];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] m_s1, m_s2, m_lvl;
  int         m_run[2];
  int         m_hold[2];
  int         cnt_p[2], cnt_r[2], cnt_rp[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_lvl = '0;
    for (int c = 0; c < 2; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      cnt_p[c]  = 0;
      cnt_r[c]  = 0;
      cnt_rp[c] = 0;
    end
  endtask

  // Drive one cycle of raw input, push the model's expectation, compare after the edge.
  task automatic step(input logic [1:0] raw);
    obs_t e, a;
    logic s2o;
    @(negedge GCLK);
    btn_raw = raw;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      s2o     = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      if (s2o != m_lvl[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DB + 1) begin
        m_run[c] = 0;
        m_lvl[c] = s2o;
        if (s2o) begin
          e.prs[c]  = 1'b1;
          m_hold[c] = 0;
        end else begin
          e.rel[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        m_hold[c]++;
        if (m_hold[c] == DLY || (m_hold[c] > DLY && (m_hold[c] - DLY) % PER == 0))
          e.rpt[c] = 1'b1;
      end
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
    @(posedge GCLK);
    #1;
    a = {btn_level, btn_press, btn_release, btn_repeat};
    e = exp_q.pop_front();
    check("sb_outputs{lvl,prs,rel,rpt}", 32'(a), 32'(e));
    for (int c = 0; c < 2; c++) begin
      cnt_p[c]  += int'(btn_press[c]);
      cnt_r[c]  += int'(btn_release[c]);
      cnt_rp[c] += int'(btn_repeat[c]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int first_p, first_rp;
    // raw, cycles, end level, press0/1, release0/1, repeat0/1
    segs[0]  = '{2'b11, 10, 2'b11, 1, 1, 0, 0, 0, 0};  // held through reset
    segs[1]  = '{2'b00, 10, 2'b00, 0, 0, 1, 1, 0, 0};
    segs[2]  = '{2'b01, 10, 2'b01, 1, 0, 0, 0, 0, 0};  // clean press ch0
    segs[3]  = '{2'b01, 57, 2'b01, 0, 0, 0, 0, 6, 0};  // repeats at +20..+60
    segs[4]  = '{2'b00, 10, 2'b00, 0, 0, 1, 0, 0, 0};
    segs[5]  = '{2'b10,  3, 2'b00, 0, 0, 0, 0, 0, 0};  // glitch ch1
    segs[6]  = '{2'b00, 10, 2'b00, 0, 0, 0, 0, 0, 0};
    segs[7]  = '{2'b01,  1, 2'b00, 0, 0, 0, 0, 0, 0};  // bounce ch0
    segs[8]  = '{2'b00,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    segs[9]  = '{2'b01,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    segs[10] = '{2'b00,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    segs[11] = '{2'b01, 10, 2'b01, 1, 0, 0, 0, 0, 0};
    segs[12] = '{2'b11, 10, 2'b11, 0, 1, 0, 0, 0, 0};
    segs[13] = '{2'b00, 10, 2'b00, 0, 0, 1, 1, 0, 0};

    RSTN    = 1'b0;
    btn_raw = 2'b11;
    model_reset();
    repeat (3) @(posedge GCLK);
    #1;
    check("outputs_in_reset", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    RSTN = 1'b1;

    for (int s = 0; s < NSEG; s++) begin
      clear_counts();
      for (int k = 0; k < segs[s].cyc; k++) step(segs[s].raw);
      check($sformatf("seg%0d_level", s), 32'(btn_level), 32'(segs[s].lvl));
      check($sformatf("seg%0d_press_cnt", s), {cnt_p[1][15:0], cnt_p[0][15:0]},
            {segs[s].p1[15:0], segs[s].p0[15:0]});
      check($sformatf("seg%0d_release_cnt", s), {cnt_r[1][15:0], cnt_r[0][15:0]},
            {segs[s].r1[15:0], segs[s].r0[15:0]});
      check($sformatf("seg%0d_repeat_cnt", s), {cnt_rp[1][15:0], cnt_rp[0][15:0]},
            {segs[s].rp1[15:0], segs[s].rp0[15:0]});
    end

    // Reset asserted while ch0 is repeating: outputs must clear without a clock edge.
    for (int k = 0; k < 27; k++) step(2'b01);
    check("repeat_before_reset", 32'(btn_repeat), 32'h1);
    #1;
    RSTN = 1'b0;
    #1;
    check("async_reset_clear", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    repeat (2) @(posedge GCLK);
    #1;
    check("held_in_reset", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    RSTN = 1'b1;
    model_reset();

    first_p  = -1;
    first_rp = -1;
    for (int k = 1; k <= 30; k++) begin
      step(2'b01);
      if (btn_press[0] && first_p < 0) first_p = k;
      if (btn_repeat[0] && first_rp < 0) first_rp = k;
    end
    check("repress_cycle_after_reset", 32'(first_p), 32'd7);
    check("first_repeat_cycle_after_reset", 32'(first_rp), 32'd27);
    clear_counts();
    for (int k = 0; k < 10; k++) step(2'b00);
    check("final_release_cnt", 32'(cnt_r[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
